// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: initiator side of the data memory read/write port.
// Turns byte-addressed byte/half/word/dword load/store requests from the
// core into word-addressed mem_read/mem_write strobes. Partial stores are
// done as read-modify-write, and loads are returned sign- or zero-extended.
// Misaligned requests get an error response and never reach memory.
// Optional feature: define DMEM_ACCESS_CTRL_WR_BYPASS_EN to add a one-entry
// buffer of the last written word. Loads and partial stores that hit it
// skip the memory read.
module dmem_access_ctrl #(
    parameter int ADDRESS_SIZE = 10,
    parameter int N            = 64,
    parameter int RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDRESS_SIZE+2:0] req_addr,
    input  logic [N-1:0]            req_wdata,
    output logic                    resp_valid,
    output logic [N-1:0]            resp_rdata,
    output logic                    resp_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_rd_addr,
    output logic [ADDRESS_SIZE-1:0] mem_wr_addr,
    output logic [N-1:0]            mem_wdata,
    input  logic [N-1:0]            mem_rdata
);

    // The wait counter must hold RD_LAT-1 for RD_LAT up to 4.
    localparam int CW = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        MERGE,
        WR,
        RESP
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic                    we_q;
    logic                    uns_q;
    logic [1:0]              size_q;
    logic [2:0]              off_q;
    logic [ADDRESS_SIZE-1:0] word_q;
    logic [N-1:0]            wdata_q;
    logic [N-1:0]            rdata_q;
    logic [CW-1:0]           lat_cnt;

    logic                    misaligned;
    logic [ADDRESS_SIZE-1:0] req_word;
    logic                    bp_hit;
    logic [N-1:0]            bp_word;
    logic [N-1:0]            src_word;
    logic [N-1:0]            load_val;
    logic [N-1:0]            merged;

    // Move the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [N-1:0] extract_lane(
        input logic [N-1:0] word,
        input logic [2:0]   off,
        input logic [1:0]   sz,
        input logic         uns
    );
        logic [N-1:0] shifted;
        logic [N-1:0] result;
        shifted = word >> {off, 3'b000};
        case (sz)
            2'b00:   result = uns ? {{(N-8){1'b0}}, shifted[7:0]}
                                  : {{(N-8){shifted[7]}}, shifted[7:0]};
            2'b01:   result = uns ? {{(N-16){1'b0}}, shifted[15:0]}
                                  : {{(N-16){shifted[15]}}, shifted[15:0]};
            2'b10:   result = uns ? {{(N-32){1'b0}}, shifted[31:0]}
                                  : {{(N-32){shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    // Replace only the addressed byte lanes of old_word with the low bytes of new_data.
    function automatic logic [N-1:0] merge_lanes(
        input logic [N-1:0] old_word,
        input logic [N-1:0] new_data,
        input logic [2:0]   off,
        input logic [1:0]   sz
    );
        logic [7:0]   lane_base;
        logic [7:0]   lane_mask;
        logic [N-1:0] shifted;
        logic [N-1:0] result;
        case (sz)
            2'b00:   lane_base = 8'h01;
            2'b01:   lane_base = 8'h03;
            2'b10:   lane_base = 8'h0F;
            default: lane_base = 8'hFF;
        endcase
        lane_mask = lane_base << off;
        shifted   = new_data << {off, 3'b000};
        for (int k = 0; k < 8; k++) begin
            result[8*k +: 8] = lane_mask[k] ? shifted[8*k +: 8] : old_word[8*k +: 8];
        end
        return result;
    endfunction

    assign req_word = req_addr[ADDRESS_SIZE+2:3];

    // Alignment check on the incoming request, based on its size.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // In the last WAIT cycle the memory word is used straight from the bus.
    // From MERGE, the captured or bypassed word is used instead.
    assign src_word = (state == WAIT) ? mem_rdata : rdata_q;
    assign load_val = extract_lane(src_word, off_q, size_q, uns_q);
    assign merged   = merge_lanes(rdata_q, wdata_q, off_q, size_q);

`ifdef DMEM_ACCESS_CTRL_WR_BYPASS_EN
    logic                    bp_valid;
    logic [ADDRESS_SIZE-1:0] bp_addr;
    logic [N-1:0]            bp_data;

    // Remember the address and full data of the most recent memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_valid <= 1'b0;
            bp_addr  <= '0;
            bp_data  <= '0;
        end else if (state == WR) begin
            bp_valid <= 1'b1;
            bp_addr  <= mem_wr_addr;
            bp_data  <= mem_wdata;
        end
    end

    assign bp_hit  = bp_valid && (bp_addr == req_word);
    assign bp_word = bp_data;
`else
    assign bp_hit  = 1'b0;
    assign bp_word = '0;
`endif

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned) begin
                        next_state = RESP;
                    end else if (req_we && (req_size == 2'b11)) begin
                        next_state = WR;
                    end else if (bp_hit) begin
                        next_state = MERGE;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                mem_read   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    next_state = we_q ? MERGE : RESP;
                end
            end
            MERGE: begin
                next_state = we_q ? WR : RESP;
            end
            WR: begin
                mem_write  = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch every request field on acceptance so inputs may change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 3'b000;
            word_q  <= '0;
            wdata_q <= '0;
        end else if ((state == IDLE) && req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            off_q   <= req_addr[2:0];
            word_q  <= req_word;
            wdata_q <= req_wdata;
        end
    end

    // Memory address and data registers. They change only when a strobe is about to be driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_addr <= '0;
            mem_wr_addr <= '0;
            mem_wdata   <= '0;
        end else begin
            if ((state == IDLE) && (next_state == RD)) begin
                mem_rd_addr <= req_word;
            end
            if (next_state == WR) begin
                mem_wr_addr <= (state == IDLE) ? req_word : word_q;
                mem_wdata   <= (state == IDLE) ? req_wdata : merged;
            end
        end
    end

    // Read-latency counter and capture of the returned or bypassed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
            rdata_q <= '0;
        end else begin
            if (state == RD) begin
                lat_cnt <= CW'(RD_LAT - 1);
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if ((state == WAIT) && (lat_cnt == '0)) begin
                rdata_q <= mem_rdata;
            end else if ((state == IDLE) && (next_state == MERGE)) begin
                rdata_q <= bp_word;
            end
        end
    end

    // Response data and error are loaded on entry to RESP and cleared when leaving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (next_state == RESP) begin
            resp_err   <= (state == IDLE);
            resp_rdata <= ((state != IDLE) && !we_q) ? load_val : '0;
        end else begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: self-checking bench for dmem_access_ctrl.
// The reference model holds memory as a flat byte array and predicts load
// data, write-back words, strobe counts and response latency for each request.
// When DMEM_ACCESS_CTRL_WR_BYPASS_EN is defined, the predicted latencies also
// account for the one-entry write bypass buffer.
module tb_dmem_access_ctrl;

    localparam int AW     = 10;
    localparam int N      = 64;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+2:0] req_addr;
    logic [N-1:0]  req_wdata;
    logic          resp_valid;
    logic [N-1:0]  resp_rdata;
    logic          resp_err;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_rd_addr;
    logic [AW-1:0] mem_wr_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;

    logic [63:0]       phys [0:1023];
    logic [7:0]        ref_bytes [0:8191];
    logic              bp_valid;
    logic [AW-1:0]     bp_word;

    logic [RD_LAT-1:0] rd_v = '0;
    logic [63:0]       rd_d [0:RD_LAT-1];
    logic [63:0]       noise = 64'h0;

    logic [63:0]       last_rdata;
    logic              last_err;
    int                last_lat;
    logic [63:0]       last_wdata;
    logic [AW-1:0]     last_wr_addr;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDRESS_SIZE(AW),
        .N(N),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_rd_addr(mem_rd_addr),
        .mem_wr_addr(mem_wr_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Word memory with a RD_LAT-deep read pipe. Outside the valid slot, mem_rdata carries noise.
    always @(posedge clk) begin
        if (mem_write) phys[mem_wr_addr] = mem_wdata;
        rd_v[0] <= mem_read;
        rd_d[0] <= phys[mem_rd_addr];
        for (int i = RD_LAT - 1; i > 0; i--) begin
            rd_v[i] <= rd_v[i-1];
            rd_d[i] <= rd_d[i-1];
        end
        noise <= {$urandom, $urandom};
    end

    assign mem_rdata = rd_v[RD_LAT-1] ? rd_d[RD_LAT-1] : noise;

    // Flags any cycle where both memory strobes are high together.
    always @(negedge clk) begin
        if (mem_read && mem_write) excl_viol++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [12:0] a, input int nb, input logic uns);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_bytes[int'(a) + i];
        if (!uns && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [63:0] ref_word(input logic [AW-1:0] w);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[int'(w) * 8 + i];
        return v;
    endfunction

    task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [12:0] addr, input logic [63:0] wd);
        int            nb;
        logic          mis;
        logic          hit;
        logic [AW-1:0] w;
        int            exp_lat;
        int            exp_rd;
        int            exp_wr;
        logic [63:0]   exp_data;
        logic [63:0]   exp_wword;
        int            guard;
        int            lat;
        int            n_rd;
        int            n_wr;
        logic [AW-1:0] seen_rd;
        logic [AW-1:0] seen_wr;
        logic [63:0]   seen_wd;
        logic [63:0]   got_rdata;
        logic          got_err;
        logic          got_ready;

        nb        = 1 << sz;
        mis       = (int'(addr) % nb) != 0;
        w         = addr[12:3];
        exp_data  = 64'h0;
        exp_wword = 64'h0;
`ifdef DMEM_ACCESS_CTRL_WR_BYPASS_EN
        hit = bp_valid && (bp_word == w) && !mis && !(we && sz == 2'b11);
`else
        hit = 1'b0;
`endif
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (we && sz == 2'b11) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
        end else if (we) begin
            exp_lat = hit ? 3 : 4 + RD_LAT; exp_rd = hit ? 0 : 1; exp_wr = 1;
        end else begin
            exp_lat = hit ? 2 : 2 + RD_LAT; exp_rd = hit ? 0 : 1; exp_wr = 0;
        end
        if (!mis && we) begin
            for (int i = 0; i < nb; i++) ref_bytes[int'(addr) + i] = wd[8*i +: 8];
            exp_wword = ref_word(w);
            bp_valid  = 1'b1;
            bp_word   = w;
        end else if (!mis) begin
            exp_data = ref_load(addr, nb, uns);
        end

        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 13'($urandom);
        req_wdata    = {$urandom, $urandom};

        lat = 999; n_rd = 0; n_wr = 0;
        seen_rd = '0; seen_wr = '0; seen_wd = '0;
        got_rdata = '0; got_err = 1'b0; got_ready = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mem_read) begin n_rd++; seen_rd = mem_rd_addr; end
            if (mem_write) begin n_wr++; seen_wr = mem_wr_addr; seen_wd = mem_wdata; end
            if (resp_valid) begin
                lat = k; got_rdata = resp_rdata; got_err = resp_err; got_ready = req_ready;
                break;
            end
        end

        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("resp_rdata", got_rdata, exp_data);
        checkOutput("resp_err", 64'(got_err), 64'(mis));
        checkOutput("ready_in_resp", 64'(got_ready), 64'h0);
        checkOutput("read_strobes", 64'(n_rd), 64'(exp_rd));
        checkOutput("write_strobes", 64'(n_wr), 64'(exp_wr));
        if (exp_rd == 1) checkOutput("mem_rd_addr", 64'(seen_rd), 64'(w));
        if (exp_wr == 1) begin
            checkOutput("mem_wr_addr", 64'(seen_wr), 64'(w));
            checkOutput("mem_wdata", seen_wd, exp_wword);
        end
        last_rdata   = got_rdata;
        last_err     = got_err;
        last_lat     = lat;
        last_wdata   = seen_wd;
        last_wr_addr = seen_wr;
    endtask

    // Directed test-plan steps, a mid-read reset, then randomized traffic.
    initial begin
        int resp_seen;
        int rd_seen;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        bp_valid     = 1'b0;
        bp_word      = '0;
        for (int wi = 0; wi < 1024; wi++) begin
            phys[wi] = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) ref_bytes[wi*8 + b] = phys[wi][8*b +: 8];
        end

        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'h1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'h0);
        checkOutput("rst_mem_read", 64'(mem_read), 64'h0);
        checkOutput("rst_mem_write", 64'(mem_write), 64'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 64'h0);
        checkOutput("rst_resp_err", 64'(resp_err), 64'h0);
        checkOutput("rst_mem_rd_addr", 64'(mem_rd_addr), 64'h0);
        checkOutput("rst_mem_wr_addr", 64'(mem_wr_addr), 64'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'h0);
        rst = 1'b0;

        applyStimulus(1'b1, 2'b11, 1'b0, 13'h320, 64'h1122334455667788);
        checkOutput("plan_dword_wr_addr", 64'(last_wr_addr), 64'd100);
        applyStimulus(1'b0, 2'b00, 1'b0, 13'h327, 64'h0);
        checkOutput("plan_byte_327", last_rdata, 64'h0000000000000011);
        applyStimulus(1'b1, 2'b00, 1'b0, 13'h321, 64'h00000000000000F0);
        checkOutput("plan_rmw_wdata", last_wdata, 64'h112233445566F088);
        applyStimulus(1'b0, 2'b10, 1'b0, 13'h320, 64'h0);
        checkOutput("plan_word_320", last_rdata, 64'h000000005566F088);
        applyStimulus(1'b0, 2'b00, 1'b0, 13'h321, 64'h0);
        checkOutput("plan_sbyte_321", last_rdata, 64'hFFFFFFFFFFFFFFF0);
        applyStimulus(1'b0, 2'b00, 1'b1, 13'h321, 64'h0);
        checkOutput("plan_ubyte_321", last_rdata, 64'h00000000000000F0);
        applyStimulus(1'b0, 2'b01, 1'b0, 13'h320, 64'h0);
        checkOutput("plan_shalf_320", last_rdata, 64'hFFFFFFFFFFFFF088);
        applyStimulus(1'b0, 2'b10, 1'b0, 13'h322, 64'h0);
        checkOutput("plan_misalign_err", 64'(last_err), 64'h1);
        checkOutput("plan_misalign_lat", 64'(last_lat), 64'h1);

        // Load to a word outside the bypass buffer, then reset while in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr  = 13'h400; req_wdata = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_mem_read", 64'(mem_read), 64'h0);
        checkOutput("midrst_resp_valid", 64'(resp_valid), 64'h0);
        checkOutput("midrst_req_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        bp_valid = 1'b0;
        resp_seen = 0;
        rd_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
            if (mem_read) rd_seen++;
        end
        checkOutput("midrst_no_resp", 64'(resp_seen), 64'h0);
        checkOutput("midrst_no_read", 64'(rd_seen), 64'h0);
        applyStimulus(1'b0, 2'b11, 1'b0, 13'h320, 64'h0);
        checkOutput("postrst_dword_320", last_rdata, 64'h112233445566F088);

`ifdef DMEM_ACCESS_CTRL_WR_BYPASS_EN
        applyStimulus(1'b1, 2'b11, 1'b0, 13'h320, 64'hA5A5_0123_4567_89AB);
        applyStimulus(1'b0, 2'b11, 1'b0, 13'h320, 64'h0);
        checkOutput("bypass_lat", 64'(last_lat), 64'h2);
        checkOutput("bypass_data", last_rdata, 64'hA5A5_0123_4567_89AB);
`endif

        for (int t = 0; t < 150; t++) begin
            logic [12:0] a;
            a = {10'(96 + $urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom});
        end

        checkOutput("strobe_exclusive", 64'(excl_viol), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the DATA_MEMORY read/write port; sits between the core's load/store stage and the 64-bit word-addressed data memory.
- Accepts byte-addressed load/store requests of size byte, half, word or dword, and drives mem_read/mem_write with word addresses.
- Partial stores are done as read-modify-write; loads return sign- or zero-extended results.
- Misaligned accesses are flagged and never reach memory.

Parameters:
- ADDRESS_SIZE, 10: memory word-address width; byte address is ADDRESS_SIZE+3 bits.
- N, 64: data width; fixed at 64 (8 byte lanes).
- RD_LAT, 1: memory read latency in cycles (1..4); mem_rdata is valid RD_LAT cycles after the mem_read cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDRESS_SIZE+3  byte address.
- req_wdata  in  N  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  N  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rd_addr  out  ADDRESS_SIZE  word read address.
- mem_wr_addr  out  ADDRESS_SIZE  word write address.
- mem_wdata  out  N  memory write data.
- mem_rdata  in  N  memory read data.

Behaviour:
- Reset (async): FSM to IDLE; all outputs 0 except req_ready=1. Reset mid-operation drops the in-flight request: strobes fall immediately and no response is produced.
- FSM states: IDLE, RD, WAIT, MERGE, WR, RESP.
- IDLE: req_ready=1 only here. Request accepted on the edge where req_valid && req_ready; all fields latched.
- Alignment rule: misaligned when half has addr[0]≠0, word has addr[1:0]≠0, dword has addr[2:0]≠0.
  - Misaligned -> RESP with resp_err=1 and resp_rdata=0; no memory strobe.
- Address mapping: word address = addr[ADDRESS_SIZE+2:3]; byte offset = addr[2:0]; little-endian, byte k = data[8k+7:8k].
- Load path: IDLE -> RD -> WAIT -> RESP.
  - RD: mem_read=1 for exactly one cycle.
  - WAIT: counter runs RD_LAT cycles; mem_rdata captured on the last WAIT edge.
  - Lane extracted by offset/size, then extended per req_unsigned.
  - resp_valid in cycle 2+RD_LAT after acceptance.
- Dword store: IDLE -> WR -> RESP. WR drives mem_write=1 with mem_wdata=req_wdata for one cycle; resp_valid 2 cycles after acceptance.
- Partial store: IDLE -> RD -> WAIT -> MERGE -> WR -> RESP.
  - MERGE replaces only the addressed lanes with the low bytes of req_wdata.
  - resp_valid 4+RD_LAT cycles after acceptance.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response backpressure.
- Strobe exclusivity: mem_read and mem_write are never high in the same cycle. Both are 0 in IDLE, WAIT, MERGE and RESP.
- Address outputs: mem_rd_addr/mem_wr_addr hold their last value when not strobed.
- Back-to-back: minimum request spacing is the response cycle +1.

Optional Feature:
- Macro: DMEM_ACCESS_CTRL_WR_BYPASS_EN.
- When defined: a one-entry buffer holds the word address and full 64-bit data of the last mem_write.
  - A load or partial store whose word address hits the valid entry skips RD/WAIT and uses the buffered word.
  - Load hit: resp_valid 2 cycles after acceptance. Partial-store hit: 3 cycles.
  - Buffer is cleared by reset and updated on every WR.
- When undefined: no buffer; every load and partial store reads memory.

Test Plan:
- Dword store 0x1122334455667788 to 0x320, then signed byte load 0x327 -> mem_wr_addr=100; resp_rdata=0x0000000000000011 at cycle 2+RD_LAT.
- Byte store 0xF0 to 0x321 -> RD then WR at word 100, mem_wdata=0x112233445566F088. Then signed word load 0x320 -> 0x000000005566F088.
- Signed byte load 0x321 -> 0xFFFFFFFFFFFFFFF0; same with req_unsigned=1 -> 0x00000000000000F0; signed half 0x320 -> 0xFFFFFFFFFFFFF088.
- Word load at 0x322 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after acceptance, mem_read never asserted.
- Load accepted, rst asserted during WAIT -> mem_read=0 immediately, no resp_valid, req_ready=1. A following dword load of 0x320 completes normally.
- With DMEM_ACCESS_CTRL_WR_BYPASS_EN: dword store to 0x320, then load 0x320 -> no mem_read, resp_valid 2 cycles after acceptance, data matches the stored word.
